// File: rtl/uart_echo_fifo_if.sv
// uart_echo_fifo_if: host-side RX pop and TX push handshakes of uart_echo_fifo
interface uart_echo_fifo_if;
    logic       o_RX_Valid;
    logic [7:0] o_RX_Data;
    logic       i_RX_Ready;
    logic       i_TX_Valid;
    logic [7:0] i_TX_Data;
    logic       o_TX_Ready;
    modport master (input o_RX_Valid, o_RX_Data, o_TX_Ready, output i_RX_Ready, i_TX_Valid, i_TX_Data);
    modport slave (output o_RX_Valid, o_RX_Data, o_TX_Ready, input i_RX_Ready, i_TX_Valid, i_TX_Data);
endinterface

// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo: UART receiver into an RX FIFO, transmitter fed by the host or by echoing the FIFO
module uart_echo_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16,
    parameter int PARITY_MODE  = 0
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst,
    input  logic                          i_UART_RX,
    output logic                          o_UART_TX,
    input  logic                          i_Echo_En,
    uart_echo_fifo_if.slave               host,
    output logic                          o_TX_Active,
    output logic [7:0]                    o_RX_LED,
    output logic                          o_Overflow,
    output logic                          o_Frame_Err,
    output logic                          o_Parity_Err,
    input  logic                          i_Clear_Err,
    output logic [$clog2(FIFO_DEPTH):0]   o_FIFO_Count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int NW = $clog2(CLKS_PER_BIT);
    localparam logic [NW-1:0] BIT_END  = NW'(CLKS_PER_BIT - 1);
    localparam logic [NW-1:0] HALF_END = NW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_PARITY = 3'd3, S_STOP = 3'd4;
    localparam logic [2:0] S_AFTER_DATA = (PARITY_MODE != 0) ? S_PARITY : S_STOP;

    function automatic logic par_bit(input logic [7:0] d);
        return (PARITY_MODE == 2) ? ~^d : ^d;
    endfunction

    logic          r_rx_meta, r_rx_sync, r_rx_perr, r_rx_fin, r_rx_stop;
    logic [2:0]    r_rx_state, r_rx_bit;
    logic [NW-1:0] r_rx_cnt;
    logic [7:0]    r_rx_shift;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [CW-1:0] r_count;
    logic [2:0]    r_tx_state, r_tx_bit;
    logic [NW-1:0] r_tx_cnt;
    logic [7:0]    r_tx_shift;
    logic          r_tx_par, r_tx_out, r_tx_active, r_ovf, r_ferr, r_perr;
    logic [7:0]    r_led;
    logic          w_push, w_full, w_nempty, w_wr, w_pop, w_tx_idle, w_tx_acc;
    logic [7:0]    w_tx_byte;

    // The byte is judged one cycle after the stop sample, when parity and stop are both known
    assign w_push    = r_rx_fin & r_rx_stop & ~r_rx_perr;
    assign w_nempty  = r_count != '0;
    assign w_full    = r_count == CW'(FIFO_DEPTH);
    assign w_tx_idle = r_tx_state == S_IDLE;
    assign w_tx_acc  = w_tx_idle & (i_Echo_En ? w_nempty : host.i_TX_Valid);
    assign w_tx_byte = i_Echo_En ? host.o_RX_Data : host.i_TX_Data;
    assign w_pop     = (host.o_RX_Valid & host.i_RX_Ready) | (w_tx_acc & i_Echo_En);
    assign w_wr      = w_push & (~w_full | w_pop);

    assign host.o_RX_Valid = w_nempty & ~i_Echo_En;
    assign host.o_RX_Data  = w_nempty ? r_mem[r_rd] : 8'h00;
    assign host.o_TX_Ready = w_tx_idle & ~i_Echo_En & ~i_Rst;
    assign o_UART_TX    = r_tx_out;
    assign o_TX_Active  = r_tx_active;
    assign o_RX_LED     = r_led;
    assign o_Overflow   = r_ovf;
    assign o_Frame_Err  = r_ferr;
    assign o_Parity_Err = r_perr;
    assign o_FIFO_Count = r_count;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_state <= S_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_perr  <= 1'b0;
            r_rx_fin   <= 1'b0;
            r_rx_stop  <= 1'b0;
        end else begin
            r_rx_meta <= i_UART_RX;
            r_rx_sync <= r_rx_meta;
            r_rx_fin  <= 1'b0;
            r_rx_cnt  <= r_rx_cnt + 1'b1;
            case (r_rx_state)
                S_IDLE: begin
                    r_rx_cnt <= '0;
                    if (!r_rx_sync) r_rx_state <= S_START;
                end
                S_START: if (r_rx_cnt == HALF_END) begin
                    r_rx_cnt   <= '0;
                    r_rx_bit   <= '0;
                    r_rx_perr  <= 1'b0;
                    r_rx_state <= r_rx_sync ? S_IDLE : S_DATA;
                end
                S_DATA: if (r_rx_cnt == BIT_END) begin
                    r_rx_cnt   <= '0;
                    r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                    r_rx_bit   <= r_rx_bit + 3'd1;
                    if (r_rx_bit == 3'd7) r_rx_state <= S_AFTER_DATA;
                end
                S_PARITY: if (r_rx_cnt == BIT_END) begin
                    r_rx_cnt   <= '0;
                    r_rx_perr  <= r_rx_sync != par_bit(r_rx_shift);
                    r_rx_state <= S_STOP;
                end
                S_STOP: if (r_rx_cnt == BIT_END) begin
                    r_rx_fin   <= 1'b1;
                    r_rx_stop  <= r_rx_sync;
                    r_rx_state <= S_IDLE;
                end
                default: r_rx_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (w_wr) r_mem[r_wr] <= r_rx_shift;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_led   <= '0;
            r_ovf   <= 1'b0;
            r_ferr  <= 1'b0;
            r_perr  <= 1'b0;
        end else begin
            if (w_wr) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            if (w_push) r_led <= r_rx_shift;
            r_count <= r_count + CW'(w_wr) - CW'(w_pop);
            r_ovf   <= (w_push & w_full & ~w_pop) | (r_ovf & ~i_Clear_Err);
            r_ferr  <= (r_rx_fin & ~r_rx_stop) | (r_ferr & ~i_Clear_Err);
            r_perr  <= (r_rx_fin & r_rx_perr) | (r_perr & ~i_Clear_Err);
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_tx_state  <= S_IDLE;
            r_tx_cnt    <= '0;
            r_tx_bit    <= '0;
            r_tx_shift  <= '0;
            r_tx_par    <= 1'b0;
            r_tx_out    <= 1'b1;
            r_tx_active <= 1'b0;
        end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
            case (r_tx_state)
                S_IDLE: begin
                    r_tx_cnt <= '0;
                    r_tx_bit <= '0;
                    if (w_tx_acc) begin
                        r_tx_state  <= S_START;
                        r_tx_out    <= 1'b0;
                        r_tx_active <= 1'b1;
                        r_tx_shift  <= w_tx_byte;
                        r_tx_par    <= par_bit(w_tx_byte);
                    end
                end
                S_START: if (r_tx_cnt == BIT_END) begin
                    r_tx_cnt   <= '0;
                    r_tx_state <= S_DATA;
                    r_tx_out   <= r_tx_shift[0];
                end
                S_DATA: if (r_tx_cnt == BIT_END) begin
                    r_tx_cnt   <= '0;
                    r_tx_bit   <= r_tx_bit + 3'd1;
                    r_tx_shift <= r_tx_shift >> 1;
                    r_tx_out   <= (r_tx_bit == 3'd7) ? ((PARITY_MODE != 0) ? r_tx_par : 1'b1) : r_tx_shift[1];
                    if (r_tx_bit == 3'd7) r_tx_state <= S_AFTER_DATA;
                end
                S_PARITY: if (r_tx_cnt == BIT_END) begin
                    r_tx_cnt   <= '0;
                    r_tx_state <= S_STOP;
                    r_tx_out   <= 1'b1;
                end
                S_STOP: if (r_tx_cnt == BIT_END) begin
                    r_tx_state  <= S_IDLE;
                    r_tx_active <= 1'b0;
                end
                default: r_tx_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/uart_echo_fifo.md
UART_ECHO_FIFO -- requirements
Module: uart_echo_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868: clock cycles per UART bit, minimum 4.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: RX FIFO entries, power of two, range 2..256.
REQ-003 SHALL have parameter PARITY_MODE, default 0: 0 = none, 1 = even, 2 = odd; applies to both RX and TX.
REQ-004 SHALL use a single clock with a synchronous, active-high reset.
REQ-005 i_Clk  in  1  system clock; all logic is on its rising edge.
REQ-006 i_Rst  in  1  synchronous active-high reset.
REQ-007 i_UART_RX  in  1  asynchronous serial input; idle high.
REQ-008 o_UART_TX  out  1  serial output; idle high.
REQ-009 i_Echo_En  in  1  1 = received bytes are retransmitted automatically; 0 = host mode.
REQ-010 o_RX_Valid, o_RX_Data  out  1, 8  RX FIFO head presented to the host.
REQ-011 i_RX_Ready  in  1  host pop; a pop occurs on a cycle where o_RX_Valid and i_RX_Ready are both 1.
REQ-012 i_TX_Valid, i_TX_Data  in  1, 8  host transmit request.
REQ-013 o_TX_Ready  out  1  TX engine can accept a host byte.
REQ-014 o_TX_Active  out  1  TX frame in progress.
REQ-015 o_RX_LED  out  8  last good received byte.
REQ-016 o_Overflow, o_Frame_Err, o_Parity_Err  out  1 each  sticky error flags.
REQ-017 i_Clear_Err  in  1  clears all sticky flags.
REQ-018 o_FIFO_Count  out  $clog2(FIFO_DEPTH)+1  current RX FIFO occupancy.

Function
REQ-019 i_UART_RX SHALL pass through a 2-FF synchronizer before any use.
REQ-020 RX FSM SHALL use states IDLE, START, DATA, PARITY, STOP.
REQ-021 RX IDLE SHALL move to START when the synchronized input is low.
REQ-022 RX START SHALL resample the input at CLKS_PER_BIT/2 cycles: if the input is high (glitch), go to IDLE with no flag; if low, go to DATA.
REQ-023 RX DATA SHALL sample 8 bits LSB first, one sample every CLKS_PER_BIT cycles.
REQ-024 RX PARITY (entered only when PARITY_MODE != 0) SHALL sample one parity bit, one CLKS_PER_BIT after the last data bit.
REQ-025 RX STOP SHALL sample the stop bit, then return to IDLE on the next cycle.
REQ-026 Stop bit = 0 SHALL set o_Frame_Err and discard the byte.
REQ-027 Parity mismatch SHALL set o_Parity_Err and discard the byte; if both errors occur, both flags set.
REQ-028 A good byte SHALL be pushed to the FIFO, and o_RX_LED updated, on the cycle after the stop sample.
REQ-029 Push while the FIFO is full and no pop occurs SHALL drop the byte and set o_Overflow; FIFO contents stay unchanged.
REQ-030 Push and pop in the same cycle SHALL both take effect, including when the FIFO is full; the count is unchanged.
REQ-031 Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-032 o_RX_Valid SHALL equal (count != 0) and NOT i_Echo_En.
REQ-033 o_RX_Data SHALL be the FIFO head (first-word fall-through).
REQ-034 TX FSM SHALL use states IDLE, START, DATA, PARITY, STOP.
REQ-035 Each TX state SHALL last CLKS_PER_BIT cycles; PARITY is skipped when PARITY_MODE = 0.
REQ-036 o_TX_Ready SHALL be 1 only in TX IDLE with i_Echo_En = 0.
REQ-037 A host byte SHALL be accepted when i_TX_Valid and o_TX_Ready are both 1.
REQ-038 In echo mode, TX IDLE with FIFO non-empty SHALL pop the head internally and accept it; host i_TX_Valid is ignored.
REQ-039 After an accept, o_UART_TX SHALL drive the start bit (0) from the next cycle.
REQ-040 Data SHALL go out LSB first, followed by parity (even or odd over the 8 bits), then stop (1).
REQ-041 o_TX_Active SHALL be 1 from the start bit through the end of the stop bit.
REQ-042 Changing i_Echo_En mid-frame SHALL NOT affect an in-flight RX or TX frame; it takes effect at the next TX IDLE.
REQ-043 Sticky flags SHALL hold until i_Clear_Err; if an error event and i_Clear_Err occur in the same cycle, the flag is set.

Reset
REQ-044 On i_Rst = 1 at a clock edge: both FSMs go to IDLE, the FIFO empties, and the synchronizer is loaded with 1s.
REQ-045 Reset values: o_UART_TX = 1, o_TX_Active = 0, o_TX_Ready = 0 during reset, o_RX_Valid = 0, o_RX_Data = 0, o_RX_LED = 0, o_FIFO_Count = 0, all error flags 0.
REQ-046 Reset mid-frame SHALL abort the frame with no push and no flag; o_UART_TX returns high on the next cycle.

Verification (bench: CLKS_PER_BIT = 16, FIFO_DEPTH = 4)
REQ-047 PARITY_MODE = 0, echo on, RX frame 0xA5 -> 0xA5 echoed on o_UART_TX, o_RX_LED = 0xA5, o_FIFO_Count returns to 0.
REQ-048 Echo off, 5 good RX frames with no pops -> o_FIFO_Count = 4, o_Overflow = 1; pops return the first 4 bytes in order.
REQ-049 PARITY_MODE = 1, RX 0x03 with parity bit 1 -> o_Parity_Err = 1, no push; then i_Clear_Err -> flag = 0.
REQ-050 RX 0x55 with stop bit 0 -> o_Frame_Err = 1, o_RX_LED unchanged; a 4-cycle low glitch -> no frame, no flag.
REQ-051 Host TX 0x3C with PARITY_MODE = 2 -> line bits 0, 0,0,1,1,1,1,0,0, 1, 1, each 16 cycles; o_TX_Ready = 0 throughout.
REQ-052 i_Rst asserted in the middle of TX data bits -> o_UART_TX = 1 and o_TX_Active = 0 on the next cycle; no output glitch afterwards.
